adder_bist: RTL and testbench

- On-chip stimulus generator and response checker for the 6-bit adder core. It is the initiator side of the adder's operand/result interface.
- Sweeps every (a, b) operand pair into the adder and compares the returned sum against an internally computed reference.
- Reports busy/done/pass and a saturating error count.
- Sits beside the adder inside tt_um_6bitaddr; a mode pin on ui_in selects BIST or external operands.

---
 rtl/adder_bist.sv | 183 ++++++++++++++++++
 tb/tb_adder_bist.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist.sv
// adder_bist: exhaustive (a, b) sweep into the adder with sum checking.
// Define ADDER_BIST_FAILCAP_EN to add first-mismatch capture ports.
module adder_bist #(
   parameter int WIDTH  = 6,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH:0]   dut_sum,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef ADDER_BIST_FAILCAP_EN
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_sum,
`endif
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam int         PW          = 2 * WIDTH;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;

`ifdef ADDER_BIST_FAILCAP_EN
   logic [WIDTH-1:0] fa_q, fa_d;
   logic [WIDTH-1:0] fb_q, fb_d;
   logic [WIDTH:0]   fs_q, fs_d;
`endif

   logic [WIDTH:0]   ref_sum;
   logic             mismatch;
   logic             last_vec;
   logic [ERR_W-1:0] err_inc;

   assign ref_sum  = {1'b0, a_q} + {1'b0, b_q};
   assign mismatch = dut_sum != ref_sum;
   assign last_vec = (&a_q) & (&b_q);
   assign err_inc  = (&err_q) ? err_q : err_q + ERR_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
`ifdef ADDER_BIST_FAILCAP_EN
      fa_d    = fa_q;
      fb_d    = fb_q;
      fs_d    = fs_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               a_d     = '0;
               b_d     = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
`ifdef ADDER_BIST_FAILCAP_EN
               fa_d    = '0;
               fb_d    = '0;
               fs_d    = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            // an abort discards this cycle's comparison entirely
            if (abort) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
            end else begin
               if (mismatch) begin
                  err_d = err_inc;
`ifdef ADDER_BIST_FAILCAP_EN
                  if (err_q == '0) begin
                     fa_d = a_q;
                     fb_d = b_q;
                     fs_d = dut_sum;
                  end
`endif
               end
               if (last_vec) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = !mismatch && (err_q == '0);
               end else begin
                  {a_d, b_d} = {a_q, b_q} + PW'(1);
                  state_d    = S_SETTLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
`ifdef ADDER_BIST_FAILCAP_EN
         fa_q    <= '0;
         fb_q    <= '0;
         fs_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
`ifdef ADDER_BIST_FAILCAP_EN
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fs_q    <= fs_d;
`endif
      end
   end

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
`ifdef ADDER_BIST_FAILCAP_EN
   assign fail_a    = fa_q;
   assign fail_b    = fb_q;
   assign fail_sum  = fs_q;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: scoreboarded sweeps against faultable adder models.
// Fail-capture ports are checked when ADDER_BIST_FAILCAP_EN is defined.
module tb_adder_bist;

   localparam int W    = 6;
   localparam int S    = 2;
   localparam int EW   = 8;
   localparam int NVEC = 1 << (2 * W);
   localparam int FULL = NVEC * (S + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  dut_a, dut_b;
   logic [W:0]    dut_sum;
   logic          busy, done, pass;
   logic [EW-1:0] err_count;
`ifdef ADDER_BIST_FAILCAP_EN
   logic [W-1:0]  fail_a, fail_b;
   logic [W:0]    fail_sum;
`endif

   int           mode = 0;
   logic [W-1:0] ra = '0;
   logic [W-1:0] rb = '0;
   logic [W:0]   rmask = '0;
   int           checks = 0;
   int           errors = 0;
   logic         probe_req = 1'b0;

   typedef struct {
      int            kind;
      int            cyc;
      logic          busy;
      logic          done;
      logic          pass;
      logic [EW-1:0] err;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  fa;
      logic [W-1:0]  fb;
      logic [W:0]    fsum;
   } exp_t;

   exp_t expq[$];
   exp_t last_exp;
   exp_t mon_e;

   always #5 clk = ~clk;

   adder_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(EW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .dut_a     (dut_a),
      .dut_b     (dut_b),
      .dut_sum   (dut_sum),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
`ifdef ADDER_BIST_FAILCAP_EN
      .fail_a    (fail_a),
      .fail_b    (fail_b),
      .fail_sum  (fail_sum),
`endif
      .err_count (err_count)
   );

   // 0 good, 1 sum-1 at (63,63), 2 sum bit W stuck 0, 3 xor mask at one pair
   function automatic logic [W:0] adder_model(input int m,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] fa, input logic [W-1:0] fb,
      input logic [W:0] mask);
      int         s;
      logic [W:0] r;
      s = int'(a) + int'(b);
      r = (W+1)'(s);
      if (m == 1 && a == '1 && b == '1) r = (W+1)'(s - 1);
      if (m == 2) r[W] = 1'b0;
      if (m == 3 && a == fa && b == fb) r = r ^ mask;
      return r;
   endfunction

   assign dut_sum = adder_model(mode, dut_a, dut_b, ra, rb, rmask);

   function automatic exp_t zero_exp();
      exp_t e;
      e.kind = 1; e.cyc = -1;
      e.busy = 0; e.done = 0; e.pass = 0; e.err = '0;
      e.a = '0; e.b = '0; e.fa = '0; e.fb = '0; e.fsum = '0;
      return e;
   endfunction

   function automatic exp_t model(input int m, input int abort_at);
      exp_t       e;
      int         cnt, lastv, chk, want;
      logic [W-1:0] a, b;
      logic [W:0] got;
      bit         ab;
      e   = zero_exp();
      ab  = abort_at > 0;
      cnt = 0;
      for (int v = 0; v < NVEC; v++) begin
         chk = (S + 1) * (v + 1);
         if (ab && chk >= abort_at) break;
         a    = W'(v / (1 << W));
         b    = W'(v % (1 << W));
         want = v / (1 << W) + v % (1 << W);
         got  = adder_model(m, a, b, ra, rb, rmask);
         if (int'(got) != want) begin
            if (cnt == 0) begin
               e.fa = a; e.fb = b; e.fsum = got;
            end
            cnt++;
         end
      end
      lastv  = ab ? (abort_at - 1) / (S + 1) : NVEC - 1;
      e.kind = 0;
      e.cyc  = ab ? abort_at + 1 : FULL + 1;
      e.done = 1;
      e.pass = !ab && cnt == 0;
      e.err  = (cnt > (1 << EW) - 1) ? '1 : EW'(cnt);
      e.a    = W'(lastv / (1 << W));
      e.b    = W'(lastv % (1 << W));
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d at t=%0t",
                  name, act, req, $time);
      end
   endtask

   task automatic check_rec(input string tag, input exp_t e, input int cyc);
      if (e.cyc >= 0) cmp({tag, "_cycle"}, cyc, e.cyc);
      cmp({tag, "_busy"}, busy, e.busy);
      cmp({tag, "_done"}, done, e.done);
      cmp({tag, "_pass"}, pass, e.pass);
      cmp({tag, "_err"}, err_count, e.err);
      cmp({tag, "_a"}, dut_a, e.a);
      cmp({tag, "_b"}, dut_b, e.b);
`ifdef ADDER_BIST_FAILCAP_EN
      cmp({tag, "_fail_a"}, fail_a, e.fa);
      cmp({tag, "_fail_b"}, fail_b, e.fb);
      cmp({tag, "_fail_sum"}, fail_sum, e.fsum);
`endif
   endtask

   // monitor: cycle count from each accepted start, pops on done or probe
   int cyc = 0;
   bit started = 0;
   bit go_next = 0;
   logic prev_done = 1'b0;

   always @(negedge clk) begin
      if (go_next) begin
         cyc = 1;
         started = 1;
      end else if (started) begin
         cyc++;
      end
      if (started && cyc == 1) begin
         cmp("start_busy", busy, 1);
         cmp("start_done_clr", done, 0);
         cmp("start_pass_clr", pass, 0);
         cmp("start_err_clr", err_count, 0);
      end
      if (started && busy)
         cmp("vec_order", {20'd0, dut_a, dut_b}, (cyc - 1) / (S + 1));
      if (done === 1'b1 && prev_done !== 1'b1) begin
         if (expq.size() == 0) begin
            cmp("unexpected_done", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            cmp("done_kind", mon_e.kind, 0);
            check_rec("done", mon_e, cyc);
         end
      end
      if (probe_req) begin
         if (expq.size() == 0) begin
            cmp("probe_queue_empty", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            cmp("probe_kind", mon_e.kind, 1);
            check_rec("probe", mon_e, cyc);
         end
      end
      prev_done = done;
      go_next = start && (busy === 1'b0) && !rst;
      if (rst) started = 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input exp_t e);
      e.kind = 1;
      e.cyc = -1;
      expq.push_back(e);
      probe_req = 1'b1;
      tick();
      probe_req = 1'b0;
   endtask

   // abort_at: <0 none, 0 together with start, >0 cycle after start
   task automatic run(input int m, input int abort_at,
                      input int restart_at, input int rst_at);
      exp_t e;
      int   c;
      bit   fin;
      mode = m;
      e = model(m, abort_at);
      if (rst_at <= 0) begin
         expq.push_back(e);
         last_exp = e;
      end
      start = 1'b1;
      if (abort_at == 0) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      c = 1;
      fin = 0;
      while (!fin) begin
         if (c == restart_at) start = 1'b1;
         if (c == abort_at) abort = 1'b1;
         if (c == rst_at) rst = 1'b1;
         tick();
         start = 1'b0;
         abort = 1'b0;
         if (rst) begin
            rst = 1'b0;
            last_exp = zero_exp();
            probe(last_exp);
            fin = 1;
         end else if (done) begin
            fin = 1;
         end else if (c >= FULL + 10) begin
            cmp("done_timeout", c, e.cyc);
            expq.delete();
            fin = 1;
         end
         c++;
      end
   endtask

   initial begin
      int v, ab;
      tick();
      tick();
      rst = 1'b0;
      probe(zero_exp());

      abort = 1'b1;
      tick();
      abort = 1'b0;
      probe(zero_exp());

      run(0, -1, -1, -1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      probe(last_exp);

      run(1, -1, -1, -1);
      run(2, 0, -1, -1);
      run(0, -1, 500, -1);
      run(0, 1000, -1, -1);

      run(0, -1, -1, $urandom_range(10, 2000));
      run(0, -1, -1, -1);

      for (int k = 0; k < 2; k++) begin
         v = $urandom_range(0, 900);
         ra = W'(v / (1 << W));
         rb = W'(v % (1 << W));
         rmask = (W+1)'($urandom_range(1, (1 << (W + 1)) - 1));
         ab = $urandom_range(1, 3000);
         run(3, ab, (k == 1) ? ab : -1, -1);
      end

      tick();
      tick();
      cmp("queue_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
